// File: rtl/ram_access_pkg.sv
// ram_access_pkg
//   Types shared between the RAM access sequencer and the strobe-driven RAM stage.
//   op_t    : RAM operation encoding (matches the RAM's operation pin).
//   state_t : sequencer FSM states.
package ram_access_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Sequencer that sits directly in front of a strobe-driven word RAM. It accepts
//   one read/write request at a time, presents address/operation/wdata to the RAM
//   one cycle before raising mem_select, holds select high for STROBE_CYCLES
//   cycles, keeps the address stable for one more cycle, then returns a single
//   response (read data for reads, 0 for writes).
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready are
//   both 1. The producer holds valid and payload until that edge; ready may
//   depend on state only (never on valid). One request outstanding at a time.
//
//   Optional feature (macro ADDR_CHECK_EN): requests with req_addr >= WORD_AMOUNT
//   never touch the RAM and get an error response; without the macro every
//   address is forwarded and resp_err is constant 0.
//
//   Ports
//     clk, rst_n              : clock, asynchronous active-low reset
//     req_valid/ready/op/addr/wdata : request channel (op 0=READ, 1=WRITE)
//     resp_valid/ready/rdata/err    : response channel
//     mem_address/select/operation/wdata : driven to the RAM (select rise = access)
//     mem_rdata               : read data returned by the RAM
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int WORD_SIZE     = 20,
  parameter int WORD_AMOUNT   = 30,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_op,
  input  logic [$clog2(WORD_AMOUNT)-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]           req_wdata,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [WORD_SIZE-1:0]           resp_rdata,
  output logic                           resp_err,
  output logic [$clog2(WORD_AMOUNT)-1:0] mem_address,
  output logic                           mem_select,
  output logic                           mem_operation,
  output logic [WORD_SIZE-1:0]           mem_wdata,
  input  logic [WORD_SIZE-1:0]           mem_rdata
);

  localparam int AW = $clog2(WORD_AMOUNT);
  localparam int CW = $clog2(STROBE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      mem_address_q, mem_address_d;
  logic               mem_select_q, mem_select_d;
  op_t                mem_operation_q, mem_operation_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic [CW-1:0]      cnt_q, cnt_d;
`ifdef ADDR_CHECK_EN
  logic               resp_err_q, resp_err_d;
  logic               addr_bad;

  // Compared as int so the bound works even when WORD_AMOUNT is a power of two.
  assign addr_bad = (int'(req_addr) >= WORD_AMOUNT);
`endif

  always_comb begin
    state_d         = state_q;
    mem_address_d   = mem_address_q;
    mem_select_d    = mem_select_q;
    mem_operation_d = mem_operation_q;
    mem_wdata_d     = mem_wdata_q;
    resp_valid_d    = resp_valid_q;
    resp_rdata_d    = resp_rdata_q;
    cnt_d           = cnt_q;
`ifdef ADDR_CHECK_EN
    resp_err_d      = resp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef ADDR_CHECK_EN
          if (addr_bad) begin
            // Out-of-range: answer directly, RAM pins left untouched.
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else
`endif
          begin
            mem_address_d   = req_addr;
            mem_operation_d = op_t'(req_op);
            mem_wdata_d     = req_wdata;
            state_d         = SETUP;
          end
        end
      end
      SETUP: begin
        // RAM pins have been stable for a full cycle; raise select now.
        mem_select_d = 1'b1;
        cnt_d        = CNT_LOAD;
        state_d      = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          mem_select_d = 1'b0;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        resp_rdata_d = (mem_operation_q == OP_WRITE) ? '0 : mem_rdata;
        resp_valid_d = 1'b1;
`ifdef ADDR_CHECK_EN
        resp_err_d   = 1'b0;
`endif
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mem_address_q   <= '0;
      mem_select_q    <= 1'b0;
      mem_operation_q <= OP_READ;
      mem_wdata_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      cnt_q           <= '0;
`ifdef ADDR_CHECK_EN
      resp_err_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      mem_address_q   <= mem_address_d;
      mem_select_q    <= mem_select_d;
      mem_operation_q <= mem_operation_d;
      mem_wdata_q     <= mem_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      cnt_q           <= cnt_d;
`ifdef ADDR_CHECK_EN
      resp_err_q      <= resp_err_d;
`endif
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_address   = mem_address_q;
  assign mem_select    = mem_select_q;
  assign mem_operation = mem_operation_q;
  assign mem_wdata     = mem_wdata_q;
`ifdef ADDR_CHECK_EN
  assign resp_err      = resp_err_q;
`else
  assign resp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
//   Bench for ram_access_ctrl (WORD_SIZE=20, WORD_AMOUNT=30). Main instance uses
//   STROBE_CYCLES=1 and talks to a behavioural strobe-driven RAM; a second
//   instance with STROBE_CYCLES=3 is used for the latency check.
//   ADDR_CHECK_EN selects the out-of-range step.
module tb_ram_access_ctrl;

  localparam int W  = 20;
  localparam int WA = 30;
  localparam int AW = $clog2(WA);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (STROBE_CYCLES=1) ----------------
  logic          req_valid = 1'b0, req_op = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_select, mem_operation;
  logic [W-1:0]  resp_rdata, mem_wdata;
  logic [W-1:0]  mem_rdata = '0;
  logic [AW-1:0] mem_address;

  ram_access_ctrl #(.WORD_SIZE(W), .WORD_AMOUNT(WA), .STROBE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_select(mem_select),
    .mem_operation(mem_operation), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- second DUT (STROBE_CYCLES=3) ----------------
  logic          d3_req_valid = 1'b0, d3_resp_ready = 1'b0;
  logic          d3_req_ready, d3_resp_valid, d3_resp_err, d3_mem_select, d3_mem_operation;
  logic [W-1:0]  d3_resp_rdata, d3_mem_wdata;
  logic [AW-1:0] d3_mem_address;
  logic [W-1:0]  d3_mem_rdata = 20'h5A5A5;
  int            d3_sel_count = 0;

  ram_access_ctrl #(.WORD_SIZE(W), .WORD_AMOUNT(WA), .STROBE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_op(1'b0),
    .req_addr(5'd7), .req_wdata(20'h0),
    .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready),
    .resp_rdata(d3_resp_rdata), .resp_err(d3_resp_err),
    .mem_address(d3_mem_address), .mem_select(d3_mem_select),
    .mem_operation(d3_mem_operation), .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata)
  );
  always @(posedge d3_mem_select) d3_sel_count++;

  // ---------------- behavioural RAM: acts on select rising edge ----------------
  logic [W-1:0]  ram [32];
  int            sel_count = 0;
  logic [AW-1:0] last_sel_addr = '0;
  logic          last_sel_op = 1'b0;
  initial for (int i = 0; i < 32; i++) ram[i] = '0;
  always @(posedge mem_select) begin
    sel_count++;
    last_sel_addr = mem_address;
    last_sel_op   = mem_operation;
    if (mem_operation) ram[mem_address] = mem_wdata;
    else               mem_rdata = ram[mem_address];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] ref_mem [32];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  initial for (int i = 0; i < 32; i++) ref_mem[i] = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents one request, waits for its response, consumes it.
  task automatic do_req(input logic op, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                        output logic [W-1:0] rd, output logic er, output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    check("ready_wait", 32'(guard < 50), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 1'($urandom); req_addr = AW'($urandom); req_wdata = W'($urandom);
    lat = 0;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // Full transaction against the reference memory.
  task automatic txn(input string tag, input logic op, input logic [AW-1:0] addr, input logic [W-1:0] wd);
    logic [W-1:0] rd, exp;
    logic er;
    int lat, sel0;
    sel0 = sel_count;
    exp_q.push_back(op ? W'(0) : ref_mem[addr]);
    if (op) ref_mem[addr] = wd;
    do_req(op, addr, wd, rd, er, lat);
    exp = exp_q.pop_front();
    check({tag, "_rdata"}, 32'(rd), 32'(exp));
    check({tag, "_err"}, 32'(er), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_selcnt"}, 32'(sel_count - sel0), 32'd1);
    check({tag, "_seladdr"}, 32'(last_sel_addr), 32'(addr));
    check({tag, "_selop"}, 32'(last_sel_op), 32'(op));
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] rd, hold_rd;
    logic er;
    int lat, sel0;

    // reset values
    #12;
    check("rst_select", 32'(mem_select), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", 32'(resp_rdata), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_op", 32'(mem_operation), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // write/read round trip
    txn("wr5", 1'b1, 5'd5, 20'hABCDE);
    txn("rd5", 1'b0, 5'd5, 20'h0);
    check("rd5_value", 32'(ram[5]), 32'hABCDE);

    // select timing for STROBE_CYCLES=1: high after E1 and low after E2
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_op = 1'b0; req_addr = 5'd5;
    @(posedge clk); #1; req_valid = 1'b0;
    check("tim_e0_sel", 32'(mem_select), 32'd0);
    @(posedge clk); #1;
    check("tim_e1_sel", 32'(mem_select), 32'd1);
    @(posedge clk); #1;
    check("tim_e2_sel", 32'(mem_select), 32'd0);
    check("tim_e2_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check("tim_e3_valid", 32'(resp_valid), 32'd1);
    check("tim_e3_rdata", 32'(resp_rdata), 32'hABCDE);

    // stall: response held 10 cycles, a competing request must be ignored
    hold_rd = resp_rdata;
    sel0 = sel_count;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 5'd9; req_wdata = 20'h11111;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_addr = AW'($urandom_range(0, WA - 1));
      if (i == 9) begin
        check("stall_valid", 32'(resp_valid), 32'd1);
        check("stall_rdata", 32'(resp_rdata), 32'(hold_rd));
        check("stall_ready", 32'(req_ready), 32'd0);
        check("stall_select", 32'(mem_select), 32'd0);
      end
    end
    check("stall_selcnt", 32'(sel_count - sel0), 32'd0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("stall_release_valid", 32'(resp_valid), 32'd0);
    check("stall_release_ready", 32'(req_ready), 32'd1);
    check("stall_ignored_wr", 32'(ram[9]), 32'(ref_mem[9]));

    // STROBE_CYCLES=3 instance: resp_valid five edges after accept
    d3_req_valid = 1'b1;
    @(posedge clk); #1;
    d3_req_valid = 1'b0;
    lat = 0;
    while (!d3_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("sc3_lat", 32'(lat), 32'd5);
    check("sc3_rdata", 32'(d3_resp_rdata), 32'h5A5A5);
    check("sc3_selcnt", 32'(d3_sel_count), 32'd1);
    d3_resp_ready = 1'b1;
    @(posedge clk); #1;
    d3_resp_ready = 1'b0;

    // upper address boundary
`ifdef ADDR_CHECK_EN
    sel0 = sel_count;
    do_req(1'b0, 5'd31, 20'h0, rd, er, lat);
    check("oob_err", 32'(er), 32'd1);
    check("oob_rdata", 32'(rd), 32'd0);
    check("oob_lat", 32'(lat), 32'd0);
    check("oob_selcnt", 32'(sel_count - sel0), 32'd0);
    txn("wr29", 1'b1, 5'd29, 20'h13579);
    txn("rd29", 1'b0, 5'd29, 20'h0);
`else
    txn("wr29", 1'b1, 5'd29, 20'h13579);
    txn("rd29", 1'b0, 5'd29, 20'h0);
`endif

    // reset while select is high: write already strobed stands
    while (!req_ready) begin @(posedge clk); #1; end
    sel0 = sel_count;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 5'd12; req_wdata = 20'h2468A;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_sel_before", 32'(mem_select), 32'd1);
    ref_mem[12] = 20'h2468A;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sel", 32'(mem_select), 32'd0);
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_selcnt", 32'(sel_count - sel0), 32'd1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    txn("rd12_after_rst", 1'b0, 5'd12, 20'h0);

    // back-to-back random traffic
    for (int i = 0; i < 24; i++) begin
      txn("rand", 1'($urandom), AW'($urandom_range(0, WA - 1)), W'($urandom));
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
